// File: rtl/multicycle_control_unit.sv
// Control FSM for the 16-bit multicycle datapath. It sequences instruction fetch,
// decode, execute, memory access and writeback through one shared memory.
// A per-access wait counter forces HALT and sets a sticky fault when memory
// stops answering.
module multicycle_control_unit #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       mem_fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_JAL  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic              in_mem, timeout;

  // State, wait counter and sticky fault registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Next state; wait counter counts stalled cycles and is zero on entry to any memory state
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    wait_d  = '0;
    in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    timeout = in_mem && !mem_ready && (wait_q == WAIT_W'(MAX_WAIT));
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_R:          state_d = S_EXEC_R;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:  state_d = S_JUMP;
          OP_HALT:       state_d = S_HALT;
          default:       state_d = S_FETCH;  // illegal opcode behaves as nop
        endcase
      end
      S_EXEC_R:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_I_WB;
      S_I_WB:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    // A late mem_ready on the last allowed cycle beats the timeout
    if (timeout) begin
      state_d = S_HALT;
      fault_d = 1'b1;
    end else if (in_mem && !mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Datapath controls decoded from the current state (FETCH also looks at mem_ready)
  always_comb begin
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b10;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_I_WB:     reg_write = 1'b1;
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        branch_ne     = (op == OP_BNE);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        if (op == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      S_HALT:     halted = 1'b1;
      default:    halted = 1'b0;
    endcase
  end

  assign mem_fault = fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle control FSM: a table of per-cycle vectors
// plus hand sequences for timeout, HALT and asynchronous reset.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       mem_fault;
  } out_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic       mr;
    logic [3:0] st;
    out_t       exp;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] op = 4'h0;
  logic       mem_ready = 1'b0;
  logic       ir_write, pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       reg_write, alu_src_a, halted, mem_fault;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
  logic [3:0] state;

  int nvec = 0;
  int nfail = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  multicycle_control_unit #(.MAX_WAIT(3), .WAIT_W(8)) dut (
    .clock(clock), .reset(reset), .op(op), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .halted(halted), .mem_fault(mem_fault), .state(state)
  );

  out_t act;
  assign act = '{ir_write, pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_read,
                 mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                 alu_op, halted, mem_fault};

  // Expected output patterns, hand-written from the state output table
  function automatic out_t o_fetch(logic mr);
    out_t o = '0; o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; return o;
  endfunction
  function automatic out_t o_decode();
    out_t o = '0; o.alu_src_b = 2'b10; return o;
  endfunction
  function automatic out_t o_exec_r();
    out_t o = '0; o.alu_src_a = 1; o.alu_op = 2'b10; return o;
  endfunction
  function automatic out_t o_r_wb();
    out_t o = '0; o.reg_write = 1; o.reg_dst = 2'b01; return o;
  endfunction
  function automatic out_t o_addr_imm();
    out_t o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10; return o;
  endfunction
  function automatic out_t o_i_wb();
    out_t o = '0; o.reg_write = 1; return o;
  endfunction
  function automatic out_t o_mem_rd();
    out_t o = '0; o.mem_read = 1; o.iord = 1; return o;
  endfunction
  function automatic out_t o_mem_wb();
    out_t o = '0; o.reg_write = 1; o.mem_to_reg = 2'b01; return o;
  endfunction
  function automatic out_t o_mem_wr();
    out_t o = '0; o.mem_write = 1; o.iord = 1; return o;
  endfunction
  function automatic out_t o_branch(logic ne);
    out_t o = '0; o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_src = 2'b01;
    o.branch_ne = ne; return o;
  endfunction
  function automatic out_t o_jump(logic jal);
    out_t o = '0; o.pc_write = 1; o.pc_src = 2'b10;
    if (jal) begin o.reg_write = 1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; end
    return o;
  endfunction
  function automatic out_t o_halt(logic f);
    out_t o = '0; o.halted = 1; o.mem_fault = f; return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic add(input string name, input logic [3:0] o, input logic mr,
                     input logic [3:0] st, input out_t e);
    vec_t v;
    v.name = name; v.op = o; v.mr = mr; v.st = st; v.exp = e;
    vecs.push_back(v);
  endtask

  // Called at a falling edge: drive, let it settle, compare, advance one cycle
  task automatic step(input string name, input logic [3:0] o, input logic mr,
                      input logic [3:0] st, input out_t e);
    op = o; mem_ready = mr;
    #1;
    check({name, ".state"}, 32'(state), 32'(st));
    check({name, ".outs"}, 32'(act), 32'(e));
    @(negedge clock);
  endtask

  initial begin
    // R-type, zero waits: 0,1,2,3
    add("r_fetch", 4'h0, 1, 4'd0, o_fetch(1));
    add("r_dec",   4'h0, 1, 4'd1, o_decode());
    add("r_exec",  4'h0, 1, 4'd2, o_exec_r());
    add("r_wb",    4'h0, 1, 4'd3, o_r_wb());
    // lw with two stalled MEM_RD cycles: 7 cycles
    add("lw_fetch", 4'h2, 1, 4'd0, o_fetch(1));
    add("lw_dec",   4'h2, 1, 4'd1, o_decode());
    add("lw_addr",  4'h2, 1, 4'd6, o_addr_imm());
    add("lw_rd0",   4'h2, 0, 4'd7, o_mem_rd());
    add("lw_rd1",   4'h2, 0, 4'd7, o_mem_rd());
    add("lw_rd2",   4'h2, 1, 4'd7, o_mem_rd());
    add("lw_wb",    4'h2, 1, 4'd8, o_mem_wb());
    // sw with one stall
    add("sw_fetch", 4'h3, 1, 4'd0, o_fetch(1));
    add("sw_dec",   4'h3, 1, 4'd1, o_decode());
    add("sw_addr",  4'h3, 1, 4'd6, o_addr_imm());
    add("sw_wr0",   4'h3, 0, 4'd9, o_mem_wr());
    add("sw_wr1",   4'h3, 1, 4'd9, o_mem_wr());
    // addi
    add("ai_fetch", 4'h1, 1, 4'd0, o_fetch(1));
    add("ai_dec",   4'h1, 1, 4'd1, o_decode());
    add("ai_exec",  4'h1, 1, 4'd4, o_addr_imm());
    add("ai_wb",    4'h1, 1, 4'd5, o_i_wb());
    // bne then beq; mem_ready low outside memory states has no effect
    add("bne_fetch", 4'h5, 1, 4'd0, o_fetch(1));
    add("bne_dec",   4'h5, 0, 4'd1, o_decode());
    add("bne_br",    4'h5, 0, 4'd10, o_branch(1));
    add("beq_fetch", 4'h4, 1, 4'd0, o_fetch(1));
    add("beq_dec",   4'h4, 1, 4'd1, o_decode());
    add("beq_br",    4'h4, 1, 4'd10, o_branch(0));
    // jal then j
    add("jal_fetch", 4'h7, 1, 4'd0, o_fetch(1));
    add("jal_dec",   4'h7, 1, 4'd1, o_decode());
    add("jal_jump",  4'h7, 1, 4'd11, o_jump(1));
    add("j_fetch",   4'h6, 1, 4'd0, o_fetch(1));
    add("j_dec",     4'h6, 1, 4'd1, o_decode());
    add("j_jump",    4'h6, 1, 4'd11, o_jump(0));
    // illegal opcode: DECODE straight back to FETCH
    add("ill_fetch", 4'h9, 1, 4'd0, o_fetch(1));
    add("ill_dec",   4'h9, 1, 4'd1, o_decode());
    // FETCH stalls 3 cycles; ready on the MAX_WAIT cycle wins, no fault
    add("late_w0",  4'h0, 0, 4'd0, o_fetch(0));
    add("late_w1",  4'h0, 0, 4'd0, o_fetch(0));
    add("late_w2",  4'h0, 0, 4'd0, o_fetch(0));
    add("late_w3",  4'h0, 1, 4'd0, o_fetch(1));
    add("late_dec", 4'h0, 1, 4'd1, o_decode());
    add("late_ex",  4'h0, 1, 4'd2, o_exec_r());
    add("late_wb",  4'h0, 1, 4'd3, o_r_wb());

    // Reset held 3 cycles
    repeat (3) @(negedge clock);
    #1;
    check("rst.state", 32'(state), 32'd0);
    check("rst.outs", 32'(act), 32'(o_fetch(0)));
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].exp);

    // Timeout in FETCH: 4 stalled cycles then HALT with fault
    for (int i = 0; i < 4; i++) step("to_fetch", 4'h0, 0, 4'd0, o_fetch(0));
    for (int i = 0; i < 3; i++) step("to_halt", 4'h0, 1, 4'd12, o_halt(1));
    reset = 1'b1;
    #1;
    check("to_rst.state", 32'(state), 32'd0);
    check("to_rst.fault", 32'(mem_fault), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // HALT opcode: absorbing for 10 cycles, no fault
    step("hlt_fetch", 4'hF, 1, 4'd0, o_fetch(1));
    step("hlt_dec",   4'hF, 1, 4'd1, o_decode());
    for (int i = 0; i < 10; i++) step("hlt_stay", 4'h0, 1, 4'd12, o_halt(0));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // Reset mid MEM_WR: mem_write must drop before the next clock edge
    step("rw_fetch", 4'h3, 1, 4'd0, o_fetch(1));
    step("rw_dec",   4'h3, 1, 4'd1, o_decode());
    step("rw_addr",  4'h3, 1, 4'd6, o_addr_imm());
    op = 4'h3; mem_ready = 1'b0;
    #1;
    check("rw_wr.mem_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("rw_rst.mem_write", 32'(mem_write), 32'd0);
    check("rw_rst.state", 32'(state), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step("rw_after", 4'h0, 1, 4'd0, o_fetch(1));
    step("rw_after_dec", 4'h0, 1, 4'd1, o_decode());

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
